// File: rtl/clkmgra_lock_seq.sv
// Reset sequencer and lock supervisor for the clock manager, clocked from the free-running board clock.
// Optional diagnostics (RETRY_CNT, sticky LOCK_LOST) are built when CLKMGRA_LOCK_SEQ_DIAG_EN is defined.
module clkmgra_lock_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1_000_000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCKED_IN,
    output logic       DCM_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAIL,
    output logic [7:0] RETRY_CNT,
    output logic       LOCK_LOST
);

    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAXP   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] PULSE_LD   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LD  = CW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PULSE,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    rty, rty_n;
    logic          lock_m, lock_s;
    logic          retry;

    // LOCKED_IN is asynchronous to CLK; lock_s is the only consumer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= LOCKED_IN;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_PULSE;
            cnt   <= PULSE_LD;
            rty   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rty   <= rty_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rty_n   = rty;
        retry   = 1'b0;
        case (state)
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = TIMEOUT_LD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked before the timeout so it wins on the final cycle.
                if (lock_s) begin
                    state_n = ST_STABLE;
                    cnt_n   = STABLE_LD;
                end else if (cnt == '0) begin
                    retry = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    retry = 1'b1;
                end else if (cnt == '0) begin
                    state_n = ST_RUN;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    retry = 1'b1;
                end
            end
            default: begin
                state_n = ST_FAIL;
            end
        endcase

        if (retry) begin
            rty_n = (rty == 8'hFF) ? rty : rty + 8'd1;
            if ((MAX_RETRY != 0) && (32'(rty_n) >= MAX_RETRY)) begin
                state_n = ST_FAIL;
            end else begin
                state_n = ST_PULSE;
                cnt_n   = PULSE_LD;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DCM_RST <= 1'b1;
            SYS_RST <= 1'b1;
            READY   <= 1'b0;
            FAIL    <= 1'b0;
        end else begin
            DCM_RST <= (state_n == ST_PULSE) || (state_n == ST_FAIL);
            SYS_RST <= (state_n != ST_RUN);
            READY   <= (state_n == ST_RUN);
            FAIL    <= (state_n == ST_FAIL);
        end
    end

`ifdef CLKMGRA_LOCK_SEQ_DIAG_EN
    assign RETRY_CNT = rty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LOCK_LOST <= 1'b0;
        end else if ((state == ST_RUN) && !lock_s) begin
            LOCK_LOST <= 1'b1;
        end
    end
`else
    assign RETRY_CNT = 8'h00;
    assign LOCK_LOST = 1'b0;
`endif

endmodule

// File: tb/tb_clkmgra_lock_seq.sv
// Bench for clkmgra_lock_seq: directed vector table plus randomized lock activity against an elapsed-time model.
module tb_clkmgra_lock_seq;

    localparam int unsigned P_RST     = 4;
    localparam int unsigned P_TIMEOUT = 20;
    localparam int unsigned P_STABLE  = 8;
    localparam int unsigned P_MAXR    = 2;
`ifdef CLKMGRA_LOCK_SEQ_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic       LOCKED_IN;
    logic       DCM_RST;
    logic       SYS_RST;
    logic       READY;
    logic       FAIL;
    logic [7:0] RETRY_CNT;
    logic       LOCK_LOST;

    clkmgra_lock_seq #(
        .RST_CYCLES   (P_RST),
        .LOCK_TIMEOUT (P_TIMEOUT),
        .STABLE_CYCLES(P_STABLE),
        .MAX_RETRY    (P_MAXR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LOCKED_IN(LOCKED_IN),
        .DCM_RST  (DCM_RST),
        .SYS_RST  (SYS_RST),
        .READY    (READY),
        .FAIL     (FAIL),
        .RETRY_CNT(RETRY_CNT),
        .LOCK_LOST(LOCK_LOST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase letter plus edges elapsed in that phase.
    byte         phase;
    int unsigned t_in;
    int unsigned m_rty;
    bit          m_lost;
    bit          hist[$];

    typedef struct {
        bit          rst;
        bit          lk;
        int unsigned n;
        bit          dcm;
        bit          sys;
        bit          rdy;
        bit          fl;
        int unsigned rty;
        bit          lost;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [12:0] dut_out();
        return {DCM_RST, SYS_RST, READY, FAIL, RETRY_CNT, LOCK_LOST};
    endfunction

    function automatic logic [12:0] pack_exp(bit dcm, bit sys, bit rdy, bit fl, int unsigned rty, bit lost);
        logic [7:0] r;
        r = DIAG ? ((rty > 255) ? 8'hFF : 8'(rty)) : 8'h00;
        return {dcm, sys, rdy, fl, r, DIAG ? lost : 1'b0};
    endfunction

    function automatic logic [12:0] model_out();
        return pack_exp(phase == "P" || phase == "F", phase != "R", phase == "R",
                        phase == "F", m_rty, m_lost);
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got dcm/sys/rdy/fail=%b rty=%0d lost=%b, expected dcm/sys/rdy/fail=%b rty=%0d lost=%b",
                     name, $time, act[12:9], act[8:1], act[0], exp[12:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        phase  = "P";
        t_in   = 0;
        m_rty  = 0;
        m_lost = 0;
        hist.delete();
    endtask

    task automatic model_retry();
        m_rty++;
        if (P_MAXR != 0 && ((m_rty > 255) ? 255 : m_rty) >= P_MAXR) phase = "F";
        else phase = "P";
        t_in = 0;
    endtask

    // Lock seen by the sequencer at this edge is LOCKED_IN as sampled two edges earlier.
    task automatic model_edge();
        bit lk;
        if (RST) begin
            model_reset();
            return;
        end
        lk = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
        t_in++;
        case (phase)
            "P": if (t_in == P_RST) begin phase = "W"; t_in = 0; end
            "W": begin
                if (lk) begin phase = "S"; t_in = 0; end
                else if (t_in == P_TIMEOUT) model_retry();
            end
            "S": begin
                if (!lk) model_retry();
                else if (t_in == P_STABLE) begin phase = "R"; t_in = 0; end
            end
            "R": if (!lk) begin m_lost = 1; model_retry(); end
            default: ;
        endcase
        hist.push_back(LOCKED_IN);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic apply(input vec_t v, input string name);
        RST       = v.rst;
        LOCKED_IN = v.lk;
        if (v.rst) model_reset();
        #1;
        repeat (v.n) step();
        check(name, dut_out(), pack_exp(v.dcm, v.sys, v.rdy, v.fl, v.rty, v.lost));
    endtask

    task automatic add_glitch_prefix();
        tbl.push_back('{1, 0, 1, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 4, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 4, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 0});
    endtask

    initial begin
        RST       = 1'b1;
        LOCKED_IN = 1'b0;
        model_reset();

        // Normal lock, lock loss in RUN, relock, second loss into FAIL, async reset.
        tbl.push_back('{1, 0, 3,  1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 3,  1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1,  0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 5,  0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 10, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1,  0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 5,  0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 2,  0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1,  1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 12, 0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1,  0, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 3,  1, 1, 0, 1, 2, 1});
        tbl.push_back('{0, 1, 30, 1, 1, 0, 1, 2, 1});
        tbl.push_back('{1, 1, 0,  1, 1, 0, 0, 0, 0});
        // Two lock timeouts into FAIL.
        tbl.push_back('{1, 0, 2,  1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 4,  0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 19, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1,  1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 3,  1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1,  0, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 19, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1,  1, 1, 0, 1, 2, 0});
        tbl.push_back('{0, 1, 40, 1, 1, 0, 1, 2, 0});
        // Glitch in STABLE, then clean lock reaches RUN.
        add_glitch_prefix();
        tbl.push_back('{0, 1, 12, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 1,  0, 0, 1, 0, 1, 0});
        // Glitch retry, then RST while in STABLE with one retry recorded.
        add_glitch_prefix();
        tbl.push_back('{0, 1, 5,  0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0,  1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 12, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1,  0, 0, 1, 0, 0, 0});

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Randomized lock activity with occasional asynchronous resets.
        for (int ep = 0; ep < 30; ep++) begin
            RST = 1'b1;
            LOCKED_IN = 1'($urandom_range(0, 1));
            model_reset();
            #1;
            check("rand_rst", dut_out(), model_out());
            repeat (2) step();
            RST = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 15) == 0) LOCKED_IN = ~LOCKED_IN;
                if ($urandom_range(0, 299) == 0) begin
                    RST = 1'b1;
                    model_reset();
                    #1;
                    check("rand_async_rst", dut_out(), model_out());
                end else begin
                    RST = 1'b0;
                end
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clkmgra_lock_seq.md
# clkmgra_lock_seq

Reset sequencer and lock supervisor for the clock manager. Drives the clock manager's RST input, watches its LOCKED output, retries on lock timeout or loss of lock, and produces a clean reset for user logic. It runs on a free-running board clock, never on a clock-manager output, so it keeps working while the clock manager is unlocked.

## Interface
- RST_CYCLES, 16: DCM_RST pulse length in CLK cycles; minimum 3.
- LOCK_TIMEOUT, 1_000_000: number of CLK cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024: number of consecutive locked cycles required before user reset is released.
- MAX_RETRY, 0: number of failed attempts before entering FAIL; 0 means retry forever.
- CLK  input  1  free-running reference clock (board oscillator, 125 MHz nominal).
- RST  input  1  asynchronous, active-high reset.
- LOCKED_IN  input  1  LOCKED from the clock manager; asynchronous to CLK.
- DCM_RST  output  1  reset to the clock manager, active-high.
- SYS_RST  output  1  user-logic reset, active-high; asserts asynchronously with RST, deasserts synchronously to CLK.
- READY  output  1  high only in RUN.
- FAIL  output  1  high only in FAIL.
- RETRY_CNT  output  8  number of retry events, saturating at 255 (diagnostic).
- LOCK_LOST  output  1  sticky flag: lock dropped while in RUN (diagnostic).

## Operation
- LOCKED_IN passes through a 2-flop synchronizer to give lock_s. Nothing else samples LOCKED_IN.
- The block has one down-counter, cnt, sized to the largest parameter (use $clog2), and one internal retry counter, rty.
- States:
  - PULSE: DCM_RST=1. Loads RST_CYCLES-1 on entry and counts down. At 0, go to WAIT_LOCK.
  - WAIT_LOCK: DCM_RST=0. Counts LOCK_TIMEOUT cycles.
    - lock_s=1: go to STABLE.
    - Timeout with no lock: retry event.
    - lock_s=1 on the timeout cycle: lock wins, go to STABLE.
  - STABLE: needs STABLE_CYCLES consecutive cycles of lock_s=1, then go to RUN. If lock_s=0 first: retry event.
  - RUN: SYS_RST=0, READY=1. If lock_s=0: set LOCK_LOST, assert SYS_RST, and take a retry event.
  - FAIL: DCM_RST=1, SYS_RST=1, FAIL=1. The only exit is RST.
- Retry event:
  - rty increments, saturating at 255.
  - If MAX_RETRY≠0 and rty reaches MAX_RETRY, go to FAIL; otherwise go to PULSE.
  - rty is never cleared by reaching RUN; it counts for the lifetime of the reset.
- SYS_RST=1 in every state except RUN.
- All outputs are registered.

## Timing
- Reset values: state=PULSE, cnt=RST_CYCLES-1, DCM_RST=1, SYS_RST=1, READY=0, FAIL=0, RETRY_CNT=0, LOCK_LOST=0, synchronizer=0.
- After RST deasserts, DCM_RST stays high for exactly RST_CYCLES CLK edges.
- A LOCKED_IN transition reaches lock_s after 2 CLK edges. The state reacts on the following edge, and outputs change with the state.
- Lock rise to SYS_RST release: 2 (synchronizer) + 1 (into STABLE) + STABLE_CYCLES edges.
- Lock drop in RUN to SYS_RST=1: 3 edges. DCM_RST=1 on the same edge.
- RST asserted mid-operation: all outputs take their reset values immediately (asynchronously), and the sequence restarts from PULSE.
- LOCKED_IN high during PULSE is ignored. WAIT_LOCK still requires lock_s=1 after DCM_RST falls.

## Configuration
- CLKMGRA_LOCK_SEQ_DIAG_EN defined: RETRY_CNT drives rty and LOCK_LOST is a live sticky flag.
- Not defined: RETRY_CNT is tied to 8'h00 and LOCK_LOST to 0, and the sticky register is not built.
- In both cases rty exists internally, because MAX_RETRY needs it. Sequencing behaviour is identical with and without the macro.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, diag macro defined.
- Normal lock: release RST and raise LOCKED_IN 5 cycles after DCM_RST falls -> DCM_RST high for 4 cycles; SYS_RST falls and READY rises 11 cycles after LOCKED_IN rises; RETRY_CNT=0.
- Timeout: hold LOCKED_IN=0 -> DCM_RST re-pulses 20 cycles after it falls, RETRY_CNT=1; after the second timeout, FAIL=1, DCM_RST=1, SYS_RST=1, RETRY_CNT=2, and this state holds until RST.
- Glitch in STABLE: drop LOCKED_IN for 1 cycle, 4 cycles after it rises -> no RUN, DCM_RST re-pulses, RETRY_CNT=1; a subsequent clean lock reaches RUN.
- Lock loss in RUN: drop LOCKED_IN -> SYS_RST=1, READY=0 and DCM_RST=1 after 3 cycles; LOCK_LOST=1 and stays 1 after relock; RETRY_CNT=1.
- Mid-operation reset: assert RST during STABLE with RETRY_CNT=1 -> all outputs return to reset values with no clock edge; RETRY_CNT=0 and LOCK_LOST=0.
- Macro undefined: repeat the timeout test -> RETRY_CNT=0 and LOCK_LOST=0 throughout; FAIL still asserts after 2 timeouts.
